mul4_seq_ctrl: RTL
==================

Name: mul4_seq_ctrl

Overview:
- Sequencing controller that computes a WIDTH x WIDTH unsigned product by time-multiplexing one external 4x4 unsigned array multiplier.
- Each cycle it issues one nibble pair to the multiplier, then shifts and accumulates the 8-bit partial product into a wide accumulator.
- Sits between a valid/ready operand source and a valid/ready result sink; the 4x4 multiplier is a purely combinational sibling instance.

Parameters:
- WIDTH, 8: operand width in bits; legal values 8 or 16. K = WIDTH/4 nibbles per operand; K*K partial products.
- GUARD, 8: extra accumulator MSBs, used only when MAC_EN is defined.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  controller can accept operands.
- in_a  in  WIDTH  multiplicand.
- in_b  in  WIDTH  multiplier.
- mul_a  out  4  nibble to external multiplier, A side.
- mul_b  out  4  nibble to external multiplier, B side.
- mul_p  in  8  combinational product mul_a*mul_b, valid in the same cycle.
- out_valid  out  1  result valid.
- out_ready  in  1  sink accepts result.
- out_p  out  ACC_W  result; ACC_W = 2*WIDTH, or 2*WIDTH+GUARD with MAC_EN.
- busy  out  1  high in MUL or DONE.

Behaviour:
- All state updates on rising clk. Reset is sampled only at clk edges.
- While rst_n=0 at an edge: state<=IDLE, acc<=0, idx<=0, operand regs<=0.
- Outputs after reset: out_valid=0, busy=0, in_ready=1, mul_a=mul_b=0, out_p=0.
- FSM states: IDLE, MUL, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: capture in_a/in_b, clear acc, idx<=0, go to MUL.
- MUL:
  - in_ready=0.
  - idx runs 0..K*K-1; i = idx mod K (A nibble), j = idx / K (B nibble).
  - mul_a = a[4i+3:4i], mul_b = b[4j+3:4j].
  - Each edge: acc <= acc + (mul_p << 4*(i+j)), idx<=idx+1.
  - On the edge where idx=K*K-1: go to DONE.
- DONE:
  - out_valid=1; out_p=acc, held stable; in_ready=0.
  - On out_valid&out_ready: go to IDLE, out_valid falls next cycle.
- Latency: out_valid rises exactly K*K edges after the accept edge (4 for WIDTH=8, 16 for WIDTH=16).
- Throughput: one result per K*K+2 cycles minimum. No overlap; in_ready is 0 in DONE even if out_ready=1 that cycle.
- mul_a and mul_b are driven 0 outside MUL.
- Accumulation is modulo 2^ACC_W. Without MAC_EN no overflow is possible: max product (2^W-1)^2 fits in 2W bits.
- out_p is 0 in IDLE unless MAC_EN is defined.
- in_valid while busy: ignored, not captured. The source must hold in_a/in_b until accepted.
- Reset mid-MUL or mid-DONE: pending operation discarded, no out_valid pulse, returns to IDLE next cycle.
- in_a/in_b changing during MUL has no effect, since operands are registered.

Optional Feature:
- Macro: MUL4_SEQ_CTRL_MAC_EN.
- Defined:
  - Adds input port acc_clr (1 bit), sampled only with the accept handshake.
  - ACC_W = 2*WIDTH+GUARD.
  - On accept, acc is cleared only if acc_clr=1; otherwise the new product adds onto the existing acc (multiply-accumulate).
  - out_p shows acc in IDLE as well; acc wraps modulo 2^ACC_W.
- Not defined:
  - No acc_clr port; acc is cleared on every accept; ACC_W = 2*WIDTH.

Test Plan:
- Reset, then WIDTH=8, in_a=8'hFF, in_b=8'hFF, out_ready=1 -> out_valid exactly 4 edges after accept, out_p=16'hFE01; mul_a/mul_b sequence (F,F) x4.
- in_a=8'h00, in_b=8'hA5; then in_a=8'h12, in_b=8'h34 -> out_p=16'h0000, then 16'h03A8; in_ready=0 throughout MUL and DONE.
- Accept 8'h0F*8'hF0, hold out_ready=0 for 3 cycles -> out_valid stays 1 and out_p=16'h0E10 stable; in_valid pulses during the hold are ignored; IDLE one cycle after out_ready=1.
- Accept 8'h80*8'h80, drive rst_n=0 at the 2nd MUL edge -> no out_valid pulse; in_ready=1 and out_p=0 after reset.
- WIDTH=16: 16'hFFFF*16'hFFFF -> out_p=32'hFFFE0001, 16 edges after accept.
- MAC_EN, WIDTH=8: 8'h10*8'h10 with acc_clr=1, then 8'h02*8'h03 with acc_clr=0 -> out_p=24'h000100, then 24'h000106.

Source files
------------

// File: rtl/mul4_seq_ctrl.sv
// Sequential WIDTH x WIDTH unsigned multiplier controller driving one external 4x4 multiplier.
// Optional multiply-accumulate mode (acc_clr port, guard bits) enabled by MUL4_SEQ_CTRL_MAC_EN.
module mul4_seq_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned GUARD = 8,
`ifdef MUL4_SEQ_CTRL_MAC_EN
  localparam int unsigned ACC_W = 2 * WIDTH + GUARD
`else
  localparam int unsigned ACC_W = 2 * WIDTH + 0 * GUARD
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef MUL4_SEQ_CTRL_MAC_EN
  input  logic             acc_clr,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [3:0]       mul_a,
  output logic [3:0]       mul_b,
  input  logic [7:0]       mul_p,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_p,
  output logic             busy
);

  localparam int unsigned K     = WIDTH / 4;
  localparam int unsigned KK    = K * K;
  localparam int unsigned K_W   = $clog2(K);
  localparam int unsigned IDX_W = $clog2(KK);
  localparam int unsigned SH_W  = K_W + 3;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t             r_state, w_state_nxt;
  logic [IDX_W-1:0]   r_idx, w_idx_nxt;
  logic [WIDTH-1:0]   r_a, r_b, w_a_nxt, w_b_nxt;
  logic [ACC_W-1:0]   r_acc, w_acc_nxt;
  logic [3:0]         r_mul_a, r_mul_b, w_mul_a_nxt, w_mul_b_nxt;
  logic               r_in_ready, r_out_valid, r_busy;
  logic               w_in_ready_nxt, w_out_valid_nxt, w_busy_nxt;

  logic [IDX_W-1:0]   w_idx_inc;
  logic [K_W:0]       w_ij;
  logic [SH_W-1:0]    w_sh;
  logic [ACC_W-1:0]   w_acc_start;

  function automatic logic [3:0] nib(input logic [WIDTH-1:0] v, input logic [K_W-1:0] k);
    return v[{k, 2'b00} +: 4];
  endfunction

  // Partial-product weight: 4*(i+j) for the pair issued this cycle.
  assign w_ij      = {1'b0, r_idx[K_W-1:0]} + {1'b0, r_idx[IDX_W-1:K_W]};
  assign w_sh      = {w_ij, 2'b00};
  assign w_idx_inc = r_idx + IDX_W'(1);

`ifdef MUL4_SEQ_CTRL_MAC_EN
  assign w_acc_start = acc_clr ? '0 : r_acc;
`else
  assign w_acc_start = '0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_acc       <= '0;
      r_mul_a     <= 4'h0;
      r_mul_b     <= 4'h0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_a         <= w_a_nxt;
      r_b         <= w_b_nxt;
      r_acc       <= w_acc_nxt;
      r_mul_a     <= w_mul_a_nxt;
      r_mul_b     <= w_mul_b_nxt;
      r_in_ready  <= w_in_ready_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  // Nibble outputs are registered one step ahead so they line up with r_idx.
  always_comb begin
    w_state_nxt     = r_state;
    w_idx_nxt       = r_idx;
    w_a_nxt         = r_a;
    w_b_nxt         = r_b;
    w_acc_nxt       = r_acc;
    w_mul_a_nxt     = 4'h0;
    w_mul_b_nxt     = 4'h0;
    w_in_ready_nxt  = r_in_ready;
    w_out_valid_nxt = r_out_valid;
    w_busy_nxt      = r_busy;

    unique case (r_state)
      S_IDLE: begin
        if (in_valid && r_in_ready) begin
          w_state_nxt    = S_MUL;
          w_a_nxt        = in_a;
          w_b_nxt        = in_b;
          w_idx_nxt      = '0;
          w_acc_nxt      = w_acc_start;
          w_mul_a_nxt    = in_a[3:0];
          w_mul_b_nxt    = in_b[3:0];
          w_in_ready_nxt = 1'b0;
          w_busy_nxt     = 1'b1;
        end
      end
      S_MUL: begin
        w_acc_nxt = r_acc + (ACC_W'(mul_p) << w_sh);
        w_idx_nxt = w_idx_inc;
        if (r_idx == IDX_W'(KK - 1)) begin
          w_state_nxt     = S_DONE;
          w_out_valid_nxt = 1'b1;
        end else begin
          w_mul_a_nxt = nib(r_a, w_idx_inc[K_W-1:0]);
          w_mul_b_nxt = nib(r_b, w_idx_inc[IDX_W-1:K_W]);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_state_nxt     = S_IDLE;
          w_out_valid_nxt = 1'b0;
          w_busy_nxt      = 1'b0;
          w_in_ready_nxt  = 1'b1;
`ifndef MUL4_SEQ_CTRL_MAC_EN
          w_acc_nxt       = '0;
`endif
        end
      end
      default: begin
        w_state_nxt     = S_IDLE;
        w_in_ready_nxt  = 1'b1;
        w_out_valid_nxt = 1'b0;
        w_busy_nxt      = 1'b0;
      end
    endcase
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign mul_a     = r_mul_a;
  assign mul_b     = r_mul_b;
  assign out_p     = r_acc;

endmodule
